// File: rtl/rgb_source_scheduler_if.sv
// Pixel-source, timing and DAC-side signal bundle for rgb_source_scheduler.
// master = pixel sources / timing generator side, slave = scheduler side.
interface rgb_source_scheduler_if #(
   parameter int UNDERRUN_W = 16
);
   logic                  video_on;
   logic                  hsync_in;
   logic                  vsync_in;
   logic [11:0]           src0_rgb;
   logic                  src0_valid;
   logic [11:0]           src1_rgb;
   logic                  src1_valid;
   logic [11:0]           src2_rgb;
   logic                  src2_valid;
   logic                  cfg_wr;
   logic [2:0]            cfg_en;
   logic [3:0]            q_r;
   logic [3:0]            q_g;
   logic [3:0]            q_b;
   logic                  hsync_out;
   logic                  vsync_out;
   logic [2:0]            grant;
   logic                  cfg_pending;
   logic [UNDERRUN_W-1:0] underrun_cnt;

   modport master (
      output video_on, hsync_in, vsync_in,
      output src0_rgb, src0_valid, src1_rgb, src1_valid, src2_rgb, src2_valid,
      output cfg_wr, cfg_en,
      input  q_r, q_g, q_b, hsync_out, vsync_out, grant, cfg_pending, underrun_cnt
   );

   modport slave (
      input  video_on, hsync_in, vsync_in,
      input  src0_rgb, src0_valid, src1_rgb, src1_valid, src2_rgb, src2_valid,
      input  cfg_wr, cfg_en,
      output q_r, q_g, q_b, hsync_out, vsync_out, grant, cfg_pending, underrun_cnt
   );
endinterface

// File: rtl/rgb_source_scheduler.sv
// Two-stage fixed-priority RGB source mux with colour-key transparency,
// frame-boundary shadowed source enables and a per-frame underrun counter.
module rgb_source_scheduler #(
   parameter logic [11:0] KEY_COLOR     = 12'hF0F,
   parameter logic [11:0] DEFAULT_COLOR = 12'h000,
   parameter logic        SYNC_POL      = 1'b0,
   parameter int          UNDERRUN_W    = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   rgb_source_scheduler_if.slave  bus
);
   localparam logic [UNDERRUN_W-1:0] ACC_MAX = {UNDERRUN_W{1'b1}};
   localparam logic [UNDERRUN_W-1:0] ACC_ONE = {{(UNDERRUN_W-1){1'b0}}, 1'b1};
   localparam logic [UNDERRUN_W-1:0] ACC_ZERO = {UNDERRUN_W{1'b0}};

   logic [11:0]           r_s1_rgb;
   logic [2:0]            r_s1_sel;
   logic                  r_s1_von;
   logic                  r_s1_hs;
   logic                  r_s1_vs;
   logic [11:0]           r_q_rgb;
   logic [2:0]            r_grant;
   logic                  r_hs_out;
   logic                  r_vs_out;
   logic [2:0]            r_active_en;
   logic [2:0]            r_pending_en;
   logic                  r_cfg_pending;
   logic [UNDERRUN_W-1:0] r_acc;
   logic [UNDERRUN_W-1:0] r_underrun_cnt;

   logic                  w_elig0;
   logic                  w_elig1;
   logic                  w_elig2;
   logic [2:0]            w_sel;
   logic [11:0]           w_sel_rgb;
   logic [11:0]           w_s2_rgb;
   logic [2:0]            w_s2_grant;
   logic                  w_fb;
   logic                  w_miss;
   logic [UNDERRUN_W-1:0] w_acc_next;

   // Eligibility and priority select; valid gates first so X colour on idle sources is masked.
   always_comb begin
      w_elig0   = bus.src0_valid && r_active_en[0];
      w_elig1   = bus.src1_valid && r_active_en[1] && (bus.src1_rgb != KEY_COLOR);
      w_elig2   = bus.src2_valid && r_active_en[2] && (bus.src2_rgb != KEY_COLOR);
      w_sel     = 3'b000;
      w_sel_rgb = 12'h000;
      if (w_elig2) begin
         w_sel     = 3'b100;
         w_sel_rgb = bus.src2_rgb;
      end else if (w_elig1) begin
         w_sel     = 3'b010;
         w_sel_rgb = bus.src1_rgb;
      end else if (w_elig0) begin
         w_sel     = 3'b001;
         w_sel_rgb = bus.src0_rgb;
      end else begin
         w_sel     = 3'b000;
         w_sel_rgb = 12'h000;
      end
   end

   // Output-stage colour: blank, default fill, or the selected source.
   always_comb begin
      w_s2_rgb   = 12'h000;
      w_s2_grant = 3'b000;
      if (!r_s1_von) begin
         w_s2_rgb   = 12'h000;
         w_s2_grant = 3'b000;
      end else if (r_s1_sel == 3'b000) begin
         w_s2_rgb   = DEFAULT_COLOR;
         w_s2_grant = 3'b000;
      end else begin
         w_s2_rgb   = r_s1_rgb;
         w_s2_grant = r_s1_sel;
      end
   end

   // Frame boundary is vsync entering its active level relative to the stage-1 copy.
   always_comb begin
      w_fb       = (bus.vsync_in == SYNC_POL) && (r_s1_vs != SYNC_POL);
      w_miss     = r_s1_von && (r_s1_sel == 3'b000);
      w_acc_next = r_acc;
      if (w_miss && (r_acc != ACC_MAX)) begin
         w_acc_next = r_acc + ACC_ONE;
      end else begin
         w_acc_next = r_acc;
      end
   end

   // Two-stage colour/sync pipeline.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_s1_rgb <= 12'h000;
         r_s1_sel <= 3'b000;
         r_s1_von <= 1'b0;
         r_s1_hs  <= ~SYNC_POL;
         r_s1_vs  <= ~SYNC_POL;
         r_q_rgb  <= 12'h000;
         r_grant  <= 3'b000;
         r_hs_out <= ~SYNC_POL;
         r_vs_out <= ~SYNC_POL;
      end else begin
         r_s1_rgb <= w_sel_rgb;
         r_s1_sel <= w_sel;
         r_s1_von <= bus.video_on;
         r_s1_hs  <= bus.hsync_in;
         r_s1_vs  <= bus.vsync_in;
         r_q_rgb  <= w_s2_rgb;
         r_grant  <= w_s2_grant;
         r_hs_out <= r_s1_hs;
         r_vs_out <= r_s1_vs;
      end
   end

   // Shadowed enables; a write landing on the boundary bypasses the shadow.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_active_en   <= 3'b001;
         r_pending_en  <= 3'b001;
         r_cfg_pending <= 1'b0;
      end else if (w_fb && bus.cfg_wr) begin
         r_active_en   <= bus.cfg_en;
         r_pending_en  <= bus.cfg_en;
         r_cfg_pending <= 1'b0;
      end else if (w_fb) begin
         if (r_cfg_pending) begin
            r_active_en   <= r_pending_en;
            r_cfg_pending <= 1'b0;
         end else begin
            r_active_en   <= r_active_en;
            r_cfg_pending <= r_cfg_pending;
         end
      end else if (bus.cfg_wr) begin
         r_pending_en  <= bus.cfg_en;
         r_cfg_pending <= 1'b1;
      end else begin
         r_cfg_pending <= r_cfg_pending;
      end
   end

   // Underrun accumulation, snapshotted and cleared at each frame boundary.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_acc          <= ACC_ZERO;
         r_underrun_cnt <= ACC_ZERO;
      end else if (w_fb) begin
         r_underrun_cnt <= w_acc_next;
         r_acc          <= ACC_ZERO;
      end else begin
         r_acc          <= w_acc_next;
      end
   end

   assign bus.q_r          = r_q_rgb[11:8];
   assign bus.q_g          = r_q_rgb[7:4];
   assign bus.q_b          = r_q_rgb[3:0];
   assign bus.grant        = r_grant;
   assign bus.hsync_out    = r_hs_out;
   assign bus.vsync_out    = r_vs_out;
   assign bus.cfg_pending  = r_cfg_pending;
   assign bus.underrun_cnt = r_underrun_cnt;
endmodule

// File: tb/tb_rgb_source_scheduler.sv
// Directed scoreboard bench: expected pixels queued at drive time, compared 2 clk later.
module tb_rgb_source_scheduler;
   typedef struct packed {
      logic [11:0] q;
      logic [2:0]  g;
      logic        hs;
      logic        vs;
   } exp_t;

   logic   clk;
   logic   reset;
   int     n_total;
   int     n_pass;
   exp_t   sb[$];

   rgb_source_scheduler_if #(.UNDERRUN_W(16)) a_if ();
   rgb_source_scheduler_if #(.UNDERRUN_W(4))  b_if ();

   rgb_source_scheduler #(.UNDERRUN_W(16)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (a_if)
   );

   rgb_source_scheduler #(.UNDERRUN_W(4)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (b_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic set_src(input logic v0, input logic [11:0] c0,
                          input logic v1, input logic [11:0] c1,
                          input logic v2, input logic [11:0] c2);
      a_if.src0_valid = v0; a_if.src0_rgb = c0;
      a_if.src1_valid = v1; a_if.src1_rgb = c1;
      a_if.src2_valid = v2; a_if.src2_rgb = c2;
   endtask

   task automatic set_vs(input logic vs);
      a_if.vsync_in = vs;
      b_if.vsync_in = vs;
   endtask

   // One clock with the current inputs; expectation for them is queued, the one from 2 clk ago checked.
   task automatic tick(input logic [11:0] eq, input logic [2:0] eg);
      exp_t e;
      e.q = eq; e.g = eg; e.hs = a_if.hsync_in; e.vs = a_if.vsync_in;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() > 1) begin
         e = sb.pop_front();
         check("q_r",       {28'd0, a_if.q_r},     {28'd0, e.q[11:8]});
         check("q_g",       {28'd0, a_if.q_g},     {28'd0, e.q[7:4]});
         check("q_b",       {28'd0, a_if.q_b},     {28'd0, e.q[3:0]});
         check("grant",     {29'd0, a_if.grant},   {29'd0, e.g});
         check("hsync_out", {31'd0, a_if.hsync_out}, {31'd0, e.hs});
         check("vsync_out", {31'd0, a_if.vsync_out}, {31'd0, e.vs});
      end
   endtask

   // One clock with reset asserted; outputs must already be in reset state after the edge.
   task automatic tick_rst();
      exp_t e;
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("rst_q",       {20'd0, a_if.q_r, a_if.q_g, a_if.q_b}, 32'd0);
      check("rst_grant",   {29'd0, a_if.grant},       32'd0);
      check("rst_hsync",   {31'd0, a_if.hsync_out},   32'd1);
      check("rst_vsync",   {31'd0, a_if.vsync_out},   32'd1);
      check("rst_pending", {31'd0, a_if.cfg_pending}, 32'd0);
      check("rst_underrun", {16'd0, a_if.underrun_cnt}, 32'd0);
      sb.delete();
      e.q = 12'h000; e.g = 3'b000; e.hs = 1'b1; e.vs = 1'b1;
      sb.push_back(e);
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      reset   = 1'b0;
      a_if.video_on = 1'b1; a_if.hsync_in = 1'b0; a_if.vsync_in = 1'b0;
      a_if.cfg_wr = 1'b1; a_if.cfg_en = 3'b111;
      set_src(1'b1, 12'h123, 1'b1, 12'h222, 1'b1, 12'h333);
      b_if.video_on = 1'b0; b_if.hsync_in = 1'b1; b_if.vsync_in = 1'b0;
      b_if.src0_valid = 1'b0; b_if.src0_rgb = 12'h000;
      b_if.src1_valid = 1'b0; b_if.src1_rgb = 12'h000;
      b_if.src2_valid = 1'b0; b_if.src2_rgb = 12'h000;
      b_if.cfg_wr = 1'b0; b_if.cfg_en = 3'b001;

      // reset with every input active
      for (int i = 0; i < 3; i++) tick_rst();
      reset = 1'b1;
      a_if.cfg_wr = 1'b0; a_if.hsync_in = 1'b1; set_vs(1'b1);
      set_src(1'b1, 12'h123, 1'b0, 12'h000, 1'b0, 12'h000);
      tick(12'h123, 3'b001);
      tick(12'h123, 3'b001);
      tick(12'h123, 3'b001);

      // enables shadowed until the frame boundary
      set_src(1'b1, 12'h111, 1'b1, 12'h222, 1'b0, 12'h000);
      tick(12'h111, 3'b001);
      a_if.cfg_wr = 1'b1; a_if.cfg_en = 3'b010;
      tick(12'h111, 3'b001);
      check("pending_set", {31'd0, a_if.cfg_pending}, 32'd1);
      a_if.cfg_wr = 1'b0;
      tick(12'h111, 3'b001);
      tick(12'h111, 3'b001);
      set_vs(1'b0);
      tick(12'h111, 3'b001);
      check("pending_clr", {31'd0, a_if.cfg_pending}, 32'd0);
      tick(12'h222, 3'b010);
      set_vs(1'b1);
      tick(12'h222, 3'b010);
      tick(12'h222, 3'b010);

      // cfg write coincident with the boundary applies at once
      set_src(1'b1, 12'h111, 1'b1, 12'h222, 1'b1, 12'h333);
      tick(12'h222, 3'b010);
      set_vs(1'b0); a_if.cfg_wr = 1'b1; a_if.cfg_en = 3'b111;
      tick(12'h222, 3'b010);
      check("pending_fb_wr", {31'd0, a_if.cfg_pending}, 32'd0);
      a_if.cfg_wr = 1'b0;
      tick(12'h333, 3'b100);
      check("pending_after", {31'd0, a_if.cfg_pending}, 32'd0);
      set_vs(1'b1);

      // priority and colour key
      set_src(1'b1, 12'h111, 1'b1, 12'h222, 1'b1, 12'hF0F);
      tick(12'h222, 3'b010);
      set_src(1'b1, 12'h111, 1'b1, 12'h222, 1'b1, 12'h333);
      tick(12'h333, 3'b100);
      set_src(1'b1, 12'h111, 1'b1, 12'hF0F, 1'b0, 12'h000);
      tick(12'h111, 3'b001);
      set_src(1'b1, 12'hF0F, 1'b0, 12'h000, 1'b0, 12'h000);
      tick(12'hF0F, 3'b001);
      set_src(1'b1, 12'h456, 1'b0, 12'hxxx, 1'b0, 12'hxxx);
      tick(12'h456, 3'b001);

      // blanking, default colour, hsync delay
      a_if.video_on = 1'b0;
      set_src(1'b1, 12'h456, 1'b0, 12'h000, 1'b0, 12'h000);
      tick(12'h000, 3'b000);
      a_if.video_on = 1'b1;
      set_src(1'b0, 12'h456, 1'b0, 12'h000, 1'b0, 12'h000);
      tick(12'h000, 3'b000);
      set_src(1'b1, 12'h789, 1'b0, 12'h000, 1'b0, 12'h000);
      a_if.hsync_in = 1'b0;
      tick(12'h789, 3'b001);
      a_if.hsync_in = 1'b1;
      tick(12'h789, 3'b001);
      tick(12'h789, 3'b001);

      // underrun: clear frame, 5 misses on a, 20 misses on the 4-bit b
      a_if.video_on = 1'b0;
      set_src(1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 12'h000);
      tick(12'h000, 3'b000);
      set_vs(1'b0);
      tick(12'h000, 3'b000);
      set_vs(1'b1);
      tick(12'h000, 3'b000);
      tick(12'h000, 3'b000);
      b_if.video_on = 1'b1;
      for (int i = 0; i < 20; i++) begin
         a_if.video_on = (i < 5);
         tick(12'h000, 3'b000);
      end
      a_if.video_on = 1'b0; b_if.video_on = 1'b0;
      for (int i = 0; i < 3; i++) tick(12'h000, 3'b000);
      set_vs(1'b0);
      tick(12'h000, 3'b000);
      check("underrun_5", {16'd0, a_if.underrun_cnt}, 32'd5);
      check("underrun_sat", {28'd0, b_if.underrun_cnt}, 32'd15);
      set_vs(1'b1);
      tick(12'h000, 3'b000);
      a_if.video_on = 1'b1;
      tick(12'h000, 3'b000);
      tick(12'h000, 3'b000);
      a_if.video_on = 1'b0;
      for (int i = 0; i < 3; i++) tick(12'h000, 3'b000);
      set_vs(1'b0);
      tick(12'h000, 3'b000);
      check("underrun_restart", {16'd0, a_if.underrun_cnt}, 32'd2);
      check("underrun_b_zero", {28'd0, b_if.underrun_cnt}, 32'd0);
      set_vs(1'b1);
      tick(12'h000, 3'b000);

      // mid-frame reset with a pending config
      a_if.cfg_wr = 1'b1; a_if.cfg_en = 3'b100;
      tick(12'h000, 3'b000);
      a_if.cfg_wr = 1'b0;
      check("pending_pre_rst", {31'd0, a_if.cfg_pending}, 32'd1);
      a_if.video_on = 1'b1;
      set_src(1'b1, 12'h111, 1'b1, 12'h222, 1'b1, 12'h333);
      tick(12'h333, 3'b100);
      tick(12'h333, 3'b100);
      tick_rst();
      reset = 1'b1;
      tick(12'h111, 3'b001);
      tick(12'h111, 3'b001);
      tick(12'h111, 3'b001);
      tick(12'h111, 3'b001);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
